// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// Tracks destination info for the instructions ahead of ID and produces
// registered ALU operand-forward selects plus the load-use stall/bubble.
//
// Only the EX and MEM tracking stages are kept. At the edge where a
// consumer enters EX, the EX producer moves to MEM (select 10) and the MEM
// producer moves to WB (select 01). The producer leaving WB at that edge
// is covered by the register file's write-before-read, so a third stage
// would never influence any output. MEM also needs no load flag: by the
// time a load reaches MEM its data is forwardable.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    input  logic             ext_stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             ex_valid_q,  ex_valid_d;
    logic [4:0]       ex_rd_q,     ex_rd_d;
    logic             ex_rw_q,     ex_rw_d;
    logic             ex_mr_q,     ex_mr_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_rd_q,    mem_rd_d;
    logic             mem_rw_q,    mem_rw_d;
    logic [1:0]       fwd_a_q,     fwd_a_d;
    logic [1:0]       fwd_b_q,     fwd_b_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic lu;

    // Register $0 is hard-wired, so a producer targeting it never matches.
    function automatic logic hit(input logic v, input logic rw,
                                 input logic [4:0] rd, input logic [4:0] r);
        return v && rw && (rd != 5'd0) && (rd == r);
    endfunction

    // Dependency matches of the ID sources against the tracked producers.
    always_comb begin
        hit_ex_rs  = hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  id_rs);
        hit_ex_rt  = hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  id_rt);
        hit_mem_rs = hit(mem_valid_q, mem_rw_q, mem_rd_q, id_rs);
        hit_mem_rt = hit(mem_valid_q, mem_rw_q, mem_rd_q, id_rt);
        lu = id_valid && ex_mr_q &&
             ((id_uses_rs && hit_ex_rs) || (id_uses_rt && hit_ex_rt));
    end

    // Stall only when a load-use hazard is not overridden by a higher-priority control.
    always_comb begin
        stall  = lu && !reset && !ext_stall && !flush;
        bubble = stall;
    end

    // Next-state selection: reset > ext_stall > flush > load-use > advance.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_rw_d    = mem_rw_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        cnt_d       = cnt_q;

        if (reset) begin
            ex_valid_d  = 1'b0;
            ex_rd_d     = 5'd0;
            ex_rw_d     = 1'b0;
            ex_mr_d     = 1'b0;
            mem_valid_d = 1'b0;
            mem_rd_d    = 5'd0;
            mem_rw_d    = 1'b0;
            fwd_a_d     = FWD_RF;
            fwd_b_d     = FWD_RF;
            cnt_d       = '0;
        end else if (!ext_stall) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_rw_d    = ex_rw_q;
            if (flush || lu) begin
                ex_valid_d = 1'b0;
                ex_rd_d    = 5'd0;
                ex_rw_d    = 1'b0;
                ex_mr_d    = 1'b0;
                fwd_a_d    = FWD_RF;
                fwd_b_d    = FWD_RF;
                if (!flush && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                ex_valid_d = id_valid;
                ex_rd_d    = id_rd;
                ex_rw_d    = id_reg_write;
                ex_mr_d    = id_mem_read;
                fwd_a_d    = FWD_RF;
                fwd_b_d    = FWD_RF;
                if (id_valid) begin
                    if (id_uses_rs && hit_ex_rs && !ex_mr_q) begin
                        fwd_a_d = FWD_MEM;
                    end else if (id_uses_rs && hit_mem_rs) begin
                        fwd_a_d = FWD_WB;
                    end
                    if (id_uses_rt && hit_ex_rt && !ex_mr_q) begin
                        fwd_b_d = FWD_MEM;
                    end else if (id_uses_rt && hit_mem_rt) begin
                        fwd_b_d = FWD_WB;
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        ex_valid_q  <= ex_valid_d;
        ex_rd_q     <= ex_rd_d;
        ex_rw_q     <= ex_rw_d;
        ex_mr_q     <= ex_mr_d;
        mem_valid_q <= mem_valid_d;
        mem_rd_q    <= mem_rd_d;
        mem_rw_q    <= mem_rw_d;
        fwd_a_q     <= fwd_a_d;
        fwd_b_q     <= fwd_b_d;
        cnt_q       <= cnt_d;
    end

    assign ForwardA    = fwd_a_q;
    assign ForwardB    = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a table of per-cycle instruction vectors with
// hand-derived expected outputs, post-edge expectations queued in a
// scoreboard, plus a counter saturation run.
module tb_fwd_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_reg_write, id_mem_read, flush, ext_stall;
    logic [1:0]    ForwardA, ForwardB;
    logic          stall, bubble;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ext_stall(ext_stall),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [4:0]    rs, rt;
        logic          urs, urt;
        logic [4:0]    rd;
        logic          rw, mr, fl, xs, rst;
        logic          chk_st;
        logic          e_st;
        logic [1:0]    e_fa, e_fb;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input bit v, input int rs, input int rt,
                                input bit urs, input bit urt, input int rd,
                                input bit rw, input bit mr, input bit fl,
                                input bit xs, input bit rst, input bit chk,
                                input bit st, input int fa, input int fb,
                                input int cnt);
        vec_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt;
        r.rd = 5'(rd); r.rw = rw; r.mr = mr; r.fl = fl; r.xs = xs;
        r.rst = rst; r.chk_st = chk; r.e_st = st;
        r.e_fa = 2'(fa); r.e_fb = 2'(fb); r.e_cnt = CW'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after an edge, check the combinational
    // stall mid-cycle, then compare the registered outputs after the edge.
    task automatic step(input string tag, input vec_t t);
        vec_t e;
        reset = t.rst; id_valid = t.v; id_rs = t.rs; id_rt = t.rt;
        id_uses_rs = t.urs; id_uses_rt = t.urt; id_rd = t.rd;
        id_reg_write = t.rw; id_mem_read = t.mr;
        flush = t.fl; ext_stall = t.xs;
        #2;
        if (t.chk_st) begin
            chk({tag, " stall"},  int'(stall),  int'(t.e_st));
            chk({tag, " bubble"}, int'(bubble), int'(t.e_st));
        end
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " ForwardA"},    int'(ForwardA),    int'(e.e_fa));
        chk({tag, " ForwardB"},    int'(ForwardB),    int'(e.e_fb));
        chk({tag, " stall_count"}, int'(stall_count), int'(e.e_cnt));
    endtask

    initial begin
        int model_cnt;
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0; ext_stall = 1'b0;

        //              v rs rt urs urt rd rw mr fl xs rst chk st fa fb cnt
        // reset state
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        // add $3,$1,$2 ; sub $4,$3,$2 ; nop
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // add $3 ; and $7,$8,$9 ; or $5,$1,$3
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 9, 1, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // add $3 ; addi $3,$3,1 ; or $5,$1,$3 (youngest producer wins)
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0));
        // lw $5,0($1) ; add $6,$5,$5 (one stall, then 01/01)
        tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1));
        // $0 producer/consumer, ALU and load
        tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // load-use coincident with flush
        tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // add $3 ; sub $4,$3,$2 ; or $5,$4,$3 frozen 3 cycles, then released
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 2, 0, 1));
        tbl.push_back(mk(1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 1, 0, 2, 0, 1));
        tbl.push_back(mk(1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 1, 0, 2, 0, 1));
        tbl.push_back(mk(1, 4, 3, 1, 1, 5, 1, 0, 0, 1, 0, 1, 0, 2, 0, 1));
        tbl.push_back(mk(1, 4, 3, 1, 1, 5, 1, 0, 0, 0, 0, 1, 0, 2, 1, 1));
        // lw $7 ; add $8,$7,$7 with reset in the stall cycle
        tbl.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Saturation: 2^CW + 2 load-use stalls.
        model_cnt = 0;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            step($sformatf("sat_lw%0d", i),
                 mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, model_cnt));
            if (model_cnt < (1 << CW) - 1) model_cnt++;
            step($sformatf("sat_use%0d", i),
                 mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0, model_cnt));
        end
        chk("sat_final", int'(stall_count), (1 << CW) - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It tracks destination-register information for instructions in EX, MEM and WB. It produces the registered `ForwardA`/`ForwardB` selects consumed by the EX-stage ALU operand muxes, using the encoding 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result. It also generates the load-use stall and bubble controls for the IF/ID and ID/EX stages.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `id_valid`  input  1  ID stage holds a real instruction.
- `id_rs`, `id_rt`  input  5 each  source register numbers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  input  1 each  the ID instruction reads that source.
- `id_rd`  input  5  final destination register of the ID instruction, after the rd/rt/$31 choice.
- `id_reg_write`  input  1  the ID instruction writes the register file.
- `id_mem_read`  input  1  the ID instruction is a load.
- `flush`  input  1  branch/jump squash; the ID instruction becomes a bubble.
- `ext_stall`  input  1  global freeze, e.g. memory busy.
- `ForwardA`  output  2  registered select for the Rs operand of the instruction in EX.
- `ForwardB`  output  2  registered select for the Rt operand of the instruction in EX.
- `stall`  output  1  combinational; hold PC and IF/ID.
- `bubble`  output  1  combinational; load a NOP into ID/EX. Equal to `stall`.
- `stall_count`  output  CNT_W  number of load-use stall cycles taken.

## Operation
- Internal tracking stages EX, MEM and WB each hold: `valid`, `rd[4:0]`, `reg_write`, `mem_read`. When the pipeline advances, values shift ID→EX→MEM→WB.
- `hit(stage, r)` is true when all of the following hold: stage `valid`, stage `reg_write`, stage `rd != 0`, and stage `rd == r`. Register $0 never forwards and never stalls.
- Load-use condition (`lu`): `id_valid` and EX `mem_read`, and either (`id_uses_rs` and `hit(EX, id_rs)`) or (`id_uses_rt` and `hit(EX, id_rt)`).
- Control priority per cycle is: `reset` > `ext_stall` > `flush` > `lu` > normal.
  - `reset`: clear all `valid` bits and `stall_count`; set `ForwardA` = `ForwardB` = 00.
  - `ext_stall`: all state holds, including `ForwardA`/`ForwardB` and `stall_count`. `stall` = 0.
  - `flush`: EX is loaded as a bubble (`valid` = 0); Forward next = 00; `stall` = 0; MEM/WB shift normally.
  - `lu`: `stall` = `bubble` = 1. EX is loaded as a bubble; Forward next = 00. EX→MEM→WB shift. `stall_count` increments, saturating at all-ones.
  - Normal: the ID fields load into EX (`valid` = `id_valid`). Forward next is computed for the instruction entering EX:
    - `ForwardA` next = 10 if `id_uses_rs`, `hit(EX, id_rs)` and EX is not `mem_read`.
    - Otherwise 01 if `id_uses_rs` and `hit(MEM, id_rs)`.
    - Otherwise 00.
    - `ForwardB` follows the same rule with `id_rt` / `id_uses_rt`.
    - If `id_valid` = 0, both are 00.
- When both EX and MEM hit, EX/MEM wins (10); the youngest producer has priority.
- A producer that has already left WB is not forwarded. The register file's write-before-read covers it.
- Code 11 is never generated.

## Timing
- `ForwardA`/`ForwardB` change only on the clock edge on which the consuming instruction enters EX. They are stable for that instruction's whole EX cycle.
- `stall`/`bubble` are combinational from the ID inputs and the EX tracking stage, valid within the same cycle. A load-use hazard costs exactly one stall cycle.
- On the cycle after a load-use stall, the load sits in MEM. The dependent instruction enters EX with select 01.
- Reset, including mid-stall: the next cycle has `stall` = 0, Forward = 00 and `stall_count` = 0.
- `stall_count` is updated one cycle after the stall cycle it counts.

## Test plan
- `add $3,…` then `sub $4,$3,$2` back-to-back → in sub's EX cycle `ForwardA` = 10, `ForwardB` = 00, `stall` never asserted.
- `add $3` then independent instruction, then `or $5,$1,$3` → `ForwardB` = 01 in or's EX cycle. Variant where `add $3` is followed by `addi $3` → consumer sees 10.
- `lw $5,0($1)` then `add $6,$5,$5` → `stall` = `bubble` = 1 for exactly one cycle. The next EX cycle for add has `ForwardA` = `ForwardB` = 01; `stall_count` = 1.
- Producer with `rd` = $0 followed by a consumer of $0 → `ForwardA` = 00 and no stall, including the load case.
- Load-use hazard coincident with `flush` = 1 → `stall` = 0, Forward next = 00, `stall_count` unchanged.
- `ext_stall` held 3 cycles mid-sequence → all outputs frozen, then resume with identical results. Assert `reset` during a stall cycle → next cycle all outputs at reset values. Drive 2^CNT_W + 2 stall cycles → `stall_count` saturates at all-ones.
